sop_example: RTL and testbench

Registered three-input sum-of-products (SOP) evaluator. On each enabled clock edge it samples inputs a, b and c and forms the 3-bit minterm index {a,b,c}. It asserts y when that minterm is set in a programmable 8-bit minterm mask. It also exposes the decoded one-hot minterm and a saturating count of true results, so the block serves both as a small logic-function primitive and as a self-checking truth-table exerciser in datapath glue.

---
 rtl/sop_example.sv | 56 +++++
 tb/tb_sop_example.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sop_example.sv
// Registered three-input sum-of-products evaluator with a programmable minterm mask,
// one-hot minterm decode and a saturating count of true results.
module sop_example #(
    parameter logic [7:0]  DEFAULT_MASK = 8'h83,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             cfg_we,
    input  logic [7:0]       cfg_mask,
    output logic             y,
    output logic             y_valid,
    output logic [7:0]       minterm,
    output logic [CNT_W-1:0] ones_count,
    output logic [7:0]       mask
);

    logic [2:0] idx;
    logic       sel;
    logic       cnt_full;

    always_comb begin
        idx      = {a, b, c};
        sel      = mask[idx];
        cnt_full = (ones_count == {CNT_W{1'b1}});
    end

    // The evaluation reads the mask register before this edge's write lands, so a
    // simultaneous cfg_we takes effect only from the following evaluation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y          <= 1'b0;
            y_valid    <= 1'b0;
            minterm    <= 8'h00;
            ones_count <= '0;
            mask       <= DEFAULT_MASK;
        end else begin
            y_valid <= en;
            if (en) begin
                y       <= sel;
                minterm <= 8'h01 << idx;
                if (sel && !cnt_full) begin
                    ones_count <= ones_count + CNT_W'(1);
                end
            end
            if (cfg_we) begin
                mask <= cfg_mask;
            end
        end
    end

endmodule

// File: tb/tb_sop_example.sv
// Randomised self-checking bench for sop_example; a truth-table model predicts every output.
module tb_sop_example;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        a = 1'b0;
    logic        b = 1'b0;
    logic        c = 1'b0;
    logic        cfg_we = 1'b0;
    logic [7:0]  cfg_mask = 8'h00;

    logic        y, y_valid, y4, y_valid4;
    logic [7:0]  minterm, mask, minterm4, mask4;
    logic [15:0] ones_count;
    logic [3:0]  ones_count4;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int exp_y, exp_v, exp_mt, exp_cnt, exp_cnt4, exp_mask;

    always #5 clk = ~clk;

    sop_example dut (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c),
        .cfg_we(cfg_we), .cfg_mask(cfg_mask),
        .y(y), .y_valid(y_valid), .minterm(minterm), .ones_count(ones_count), .mask(mask)
    );

    sop_example #(.DEFAULT_MASK(8'h83), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c),
        .cfg_we(cfg_we), .cfg_mask(cfg_mask),
        .y(y4), .y_valid(y_valid4), .minterm(minterm4), .ones_count(ones_count4),
        .mask(mask4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " y"}, 32'(y), 32'(exp_y));
        check({tag, " y_valid"}, 32'(y_valid), 32'(exp_v));
        check({tag, " minterm"}, 32'(minterm), 32'(exp_mt));
        check({tag, " ones_count"}, 32'(ones_count), 32'(exp_cnt));
        check({tag, " mask"}, 32'(mask), 32'(exp_mask));
        check({tag, " ones_count4"}, 32'(ones_count4), 32'(exp_cnt4));
    endtask

    task automatic model_reset();
        exp_y = 0; exp_v = 0; exp_mt = 0; exp_cnt = 0; exp_cnt4 = 0; exp_mask = 'h83;
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        en = 1'b0; cfg_we = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input string tag, input bit e, input int abc, input bit we,
                        input int cm);
        int idx;
        @(negedge clk);
        en = e; {a, b, c} = 3'(abc); cfg_we = we; cfg_mask = 8'(cm);
        @(posedge clk);
        idx = abc % 8;
        exp_v = e;
        if (e) begin
            exp_y  = (exp_mask >> idx) & 1;
            exp_mt = 1 << idx;
            if (exp_y == 1) begin
                if (exp_cnt < 65535) exp_cnt++;
                if (exp_cnt4 < 15) exp_cnt4++;
            end
        end
        if (we) exp_mask = cm % 256;
        #1;
        check_all(tag);
    endtask

    initial begin
        int cnt_before;
        int ylist [8];
        model_reset();
        do_reset("reset");

        // Default mask 8'h83: minterms 0, 1, 7
        ylist = '{1, 1, 0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 8; i++) begin
            step("default", 1'b1, i, 1'b0, 0);
            check("default y table", 32'(y), 32'(ylist[i]));
        end
        check("default count", 32'(ones_count), 32'd3);

        // Odd-parity mask
        step("wr96", 1'b0, 0, 1'b1, 'h96);
        check("mask 96", 32'(mask), 32'h96);
        cnt_before = exp_cnt;
        ylist = '{0, 1, 1, 0, 1, 0, 0, 1};
        for (int i = 0; i < 8; i++) begin
            step("parity", 1'b1, i, 1'b0, 0);
            check("parity y table", 32'(y), 32'(ylist[i]));
        end
        check("parity count", 32'(ones_count), 32'(cnt_before + 4));

        // Simultaneous write and evaluate uses the old mask
        do_reset("reset2");
        step("simul", 1'b1, 0, 1'b1, 'h00);
        check("simul old mask", 32'(y), 32'd1);
        step("simul next", 1'b1, 0, 1'b0, 0);
        check("simul new mask", 32'(y), 32'd0);

        // Enable gating
        step("prime", 1'b1, 7, 1'b1, 'hFF);
        for (int i = 0; i < 8; i++) step("gated", 1'b0, i, 1'b0, 0);

        // Randomised traffic with occasional mask rewrites
        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 9) == 0), int'($urandom_range(0, 255)));
        end

        // Saturation of the 4-bit counter instance
        do_reset("reset3");
        step("wrFF", 1'b0, 0, 1'b1, 'hFF);
        for (int i = 0; i < 20; i++) step("sat", 1'b1, int'($urandom_range(0, 7)), 1'b0, 0);
        check("sat count4", 32'(ones_count4), 32'd15);
        check("sat count16", 32'(ones_count), 32'd20);
        do_reset("reset mid-run");
        check("count after reset", 32'(ones_count4), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
